rggen_bit_field_counter_collector: RTL and testbench
====================================================

Name: rggen_bit_field_counter_collector

Overview:
- Register-side initiator for the `rggen_bit_field` access protocol. It drives valid, write_mask and write_data, and samples read_data of one bit field, normally a hardware counter bit field.
- Serves host single-cycle access commands through a valid/ready command and response pair.
- Autonomously polls the field with atomic read-clear accesses. Each read value is added into a wide saturating accumulator, which extends a narrow hardware counter without losing events.
- Sits between a register block (or debug bus bridge) and a counter bit field.

Parameters:
- WIDTH, 4, bit field width.
- ACC_WIDTH, 32, accumulator width; must be >= WIDTH.
- INTERVAL_WIDTH, 16, width of the poll interval.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_enable  input  1  enables periodic polling
- i_interval  input  INTERVAL_WIDTH  idle cycles between polls
- i_cmd_valid  input  1  host command valid
- o_cmd_ready  output  1  host command accepted when valid&&ready
- i_cmd_op  input  3  0 READ, 1 WRITE, 2 SET, 3 CLEAR, 4 READ_CLEAR, 5-7 treated as READ
- i_cmd_mask  input  WIDTH  bit mask for WRITE/SET/CLEAR
- i_cmd_data  input  WIDTH  write data for WRITE
- o_rsp_valid  output  1  response valid
- i_rsp_ready  input  1  response accepted
- o_rsp_data  output  WIDTH  field value before the access
- o_bf_valid  output  1  bit field access strobe
- o_bf_write_mask  output  WIDTH  bit field write mask
- o_bf_write_data  output  WIDTH  bit field write data
- i_bf_read_data  input  WIDTH  bit field read data (combinational from field)
- i_acc_clear  input  1  synchronous accumulator clear
- o_acc_value  output  ACC_WIDTH  accumulated count
- o_acc_overflow  output  1  sticky saturation flag

Behaviour:
- Reset (async, i_rst_n low) and reset mid-operation:
  - All outputs go to 0, FSM to IDLE, timer to 0, poll_pending to 0.
  - Any in-flight command or response is discarded.
- Bus stage:
  - o_bf_valid, o_bf_write_mask and o_bf_write_data are registered outputs.
  - o_bf_valid is high for exactly one cycle per access.
  - i_bf_read_data is sampled in that same cycle; it is the pre-write value.
- Op encoding on the bus:
  - READ: mask 0, data 0.
  - WRITE: mask = cmd_mask, data = cmd_data.
  - SET: mask = cmd_mask, data all-ones.
  - CLEAR: mask = cmd_mask, data 0.
  - READ_CLEAR and poll: mask all-ones, data 0.
  - Every op is a single bus cycle, so read and write are atomic.
- Host FSM:
  - States: IDLE, BUS, RESP.
  - IDLE to BUS on a handshake at cycle T. Command is registered; the bus access occurs at T+1.
  - BUS to RESP at T+1, capturing o_rsp_data. o_rsp_valid is high from T+2.
  - RESP holds o_rsp_valid and o_rsp_data stable until i_rsp_ready, then returns to IDLE.
  - o_cmd_ready = (state==IDLE) && !poll_wins. No new command is accepted while a response is pending.
- Poll timer:
  - While i_enable=1, the down-counter reloads i_interval on expiry and sets poll_pending.
  - i_interval=0 means a poll is requested every cycle.
  - i_enable=0 holds the timer at i_interval and clears poll_pending.
- Arbitration:
  - The bus stage is free whenever the host FSM is not in BUS.
  - poll_wins = poll_pending && !last_bus_was_poll. This alternation guarantees a host command is accepted within 2 cycles under continuous polling.
  - A poll may issue while the host FSM is in RESP.
  - poll_pending clears when its bus cycle issues.
- Accumulator:
  - Updates on the cycle after any read-clear bus cycle (poll or host READ_CLEAR) by adding zero-extended read data.
  - WRITE/SET/CLEAR/READ never change the accumulator.
  - Saturates at all-ones and sets o_acc_overflow (sticky).
  - i_acc_clear zeroes acc and overflow. If a read-clear lands in the same cycle, acc = read_data and overflow = 0.

Decomposition:
- Package rggen_bit_field_collector_pkg holds:
  - op enum (READ..READ_CLEAR);
  - FSM state enum;
  - bus request struct {mask, data, is_poll, is_host}.
- One sub-module, rggen_collector_poll_timer: reload down-counter plus pending flag.

Test Plan:
- READ with field model at 4'h9: accept at T -> o_bf_valid=1, mask 0 at T+1; o_rsp_valid at T+2 with data 4'h9. Hold i_rsp_ready=0 for 3 cycles -> rsp stable.
- SET mask 4'b0011 on field 4'h4 -> bus mask 4'h3, data 4'hF; field becomes 4'h7; rsp_data 4'h4. Then CLEAR mask 4'h1 -> field 4'h6.
- Counter model incrementing every cycle with i_interval=3, enable for 200 cycles, then disable and do a final READ_CLEAR -> o_acc_value equals the total increments exactly (no lost counts across read-clear).
- ACC_WIDTH=8, acc preloaded to 8'hFC, poll reads 4'h7 -> acc 8'hFF, overflow 1. Next cycle i_acc_clear with a poll reading 4'h5 -> acc 8'h05, overflow 0.
- i_interval=0, enable=1, host cmd held valid -> accepted within 2 cycles; bus alternates poll/host.
- Reset asserted while in RESP -> o_rsp_valid, o_bf_valid, o_acc_value, o_acc_overflow are 0 immediately. After release, READ completes normally.

Source files
------------

// File: rtl/rggen_bit_field_collector_pkg.sv
// Shared types for the bit field counter collector.
// Op codes, host FSM states and the bus request bundle.
package rggen_bit_field_collector_pkg;

  // Field widths up to this value fit in a bus request.
  localparam int BF_MAX_WIDTH = 64;

  typedef enum logic [2:0] {
    OP_READ       = 3'd0,
    OP_WRITE      = 3'd1,
    OP_SET        = 3'd2,
    OP_CLEAR      = 3'd3,
    OP_READ_CLEAR = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [BF_MAX_WIDTH-1:0] mask;
    logic [BF_MAX_WIDTH-1:0] data;
    logic                    is_poll;
    logic                    is_host;
  } bus_req_t;

endpackage

// File: rtl/rggen_collector_poll_timer.sv
// Poll interval down-counter with a sticky pending flag.
// Ports: i_enable/i_interval configure, i_issue clears, o_pending requests.
module rggen_collector_poll_timer #(
  parameter int INTERVAL_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  input  logic [INTERVAL_WIDTH-1:0] i_interval,
  input  logic                      i_issue,
  output logic                      o_pending
);

  logic [INTERVAL_WIDTH-1:0] count;

  // A fresh expiry wins over a same-cycle issue so no
  // request is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count     <= '0;
      o_pending <= 1'b0;
    end else if (!i_enable) begin
      count     <= i_interval;
      o_pending <= 1'b0;
    end else if (count == '0) begin
      count     <= i_interval;
      o_pending <= 1'b1;
    end else begin
      count <= count - 1'b1;
      if (i_issue) begin
        o_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rggen_bit_field_counter_collector.sv
// Host access + periodic read-clear poller for one counter bit field.
// Ports: cmd/rsp host pair, o_bf_* bus stage, i_bf_read_data, acc outputs.
module rggen_bit_field_counter_collector
  import rggen_bit_field_collector_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int ACC_WIDTH      = 32,
  parameter int INTERVAL_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  input  logic [INTERVAL_WIDTH-1:0] i_interval,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [2:0]                i_cmd_op,
  input  logic [WIDTH-1:0]          i_cmd_mask,
  input  logic [WIDTH-1:0]          i_cmd_data,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [WIDTH-1:0]          o_rsp_data,
  output logic                      o_bf_valid,
  output logic [WIDTH-1:0]          o_bf_write_mask,
  output logic [WIDTH-1:0]          o_bf_write_data,
  input  logic [WIDTH-1:0]          i_bf_read_data,
  input  logic                      i_acc_clear,
  output logic [ACC_WIDTH-1:0]      o_acc_value,
  output logic                      o_acc_overflow
);

  state_e   state;
  state_e   state_next;
  bus_req_t host_req;
  bus_req_t bus_req;
  logic     host_rc;
  logic     poll_pending;
  logic     last_poll;
  logic     poll_wins;
  logic     poll_issue;
  logic     host_issue;
  logic     bus_issue;
  logic     bus_rc;
  logic     active;
  logic     unused_req;
  logic [ACC_WIDTH:0] acc_sum;

  rggen_collector_poll_timer #(
    .INTERVAL_WIDTH (INTERVAL_WIDTH)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (i_enable),
    .i_interval (i_interval),
    .i_issue    (poll_issue),
    .o_pending  (poll_pending)
  );

  // Polls yield every other cycle so a host
  // command cannot be starved.
  assign poll_wins  = poll_pending && !last_poll;
  assign poll_issue = poll_wins && (state != ST_BUS);
  assign o_cmd_ready =
    active && (state == ST_IDLE) && !poll_wins;
  assign host_issue = i_cmd_valid && o_cmd_ready;
  assign bus_issue  = host_issue || poll_issue;
  assign o_rsp_valid = (state == ST_RESP);

  always_comb begin
    host_req         = '0;
    host_req.is_host = 1'b1;
    host_rc          = 1'b0;
    unique case (1'b1)
      i_cmd_op == OP_WRITE: begin
        host_req.mask = BF_MAX_WIDTH'(i_cmd_mask);
        host_req.data = BF_MAX_WIDTH'(i_cmd_data);
      end
      i_cmd_op == OP_SET: begin
        host_req.mask = BF_MAX_WIDTH'(i_cmd_mask);
        host_req.data = '1;
      end
      i_cmd_op == OP_CLEAR: begin
        host_req.mask = BF_MAX_WIDTH'(i_cmd_mask);
      end
      i_cmd_op == OP_READ_CLEAR: begin
        host_req.mask = '1;
        host_rc       = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus_req = host_req;
    if (poll_issue) begin
      bus_req         = '0;
      bus_req.mask    = '1;
      bus_req.is_poll = 1'b1;
    end
  end

  assign unused_req = ^bus_req;

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (host_issue) state_next = ST_BUS;
      ST_BUS:  state_next = ST_RESP;
      ST_RESP: if (i_rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      active     <= 1'b0;
      last_poll  <= 1'b0;
      o_rsp_data <= '0;
    end else begin
      state     <= state_next;
      active    <= 1'b1;
      last_poll <= poll_issue;
      if (state == ST_BUS) begin
        o_rsp_data <= i_bf_read_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bf_valid      <= 1'b0;
      o_bf_write_mask <= '0;
      o_bf_write_data <= '0;
      bus_rc          <= 1'b0;
    end else begin
      o_bf_valid      <= bus_issue;
      o_bf_write_mask <=
        bus_issue ? bus_req.mask[WIDTH-1:0] : '0;
      o_bf_write_data <=
        bus_issue ? bus_req.data[WIDTH-1:0] : '0;
      bus_rc <=
        bus_issue && (bus_req.is_poll || host_rc);
    end
  end

  // One extra bit catches the carry that
  // signals saturation.
  assign acc_sum =
    {1'b0, o_acc_value} +
    (ACC_WIDTH+1)'(i_bf_read_data);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_acc_value    <= '0;
      o_acc_overflow <= 1'b0;
    end else if (i_acc_clear) begin
      o_acc_value <=
        bus_rc ? ACC_WIDTH'(i_bf_read_data) : '0;
      o_acc_overflow <= 1'b0;
    end else if (bus_rc) begin
      if (acc_sum[ACC_WIDTH]) begin
        o_acc_value    <= '1;
        o_acc_overflow <= 1'b1;
      end else begin
        o_acc_value <= acc_sum[ACC_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rggen_bit_field_counter_collector.sv
// Bench for the counter collector: field model, host ops,
// polling, saturation, arbitration and reset.
module tb_rggen_bit_field_counter_collector;

  localparam int W  = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic [15:0]   interval = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [W-1:0]  cmd_mask = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_data;
  logic          bf_valid;
  logic [W-1:0]  bf_mask;
  logic [W-1:0]  bf_data;
  logic [W-1:0]  field = '0;
  logic          acc_clear = 1'b0;
  logic [AW-1:0] acc_value;
  logic          acc_ovf;

  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic          cnt_inc = 1'b0;
  int            inc_total = 0;
  logic [W-1:0]  nxt;

  int n_chk = 0;
  int n_pass = 0;

  logic mon_on = 1'b0;
  logic prev_poll = 1'b0;
  int   b2b = 0;
  int   polls = 0;
  int   hosts = 0;

  always #5 clk = ~clk;

  rggen_bit_field_counter_collector #(
    .WIDTH          (W),
    .ACC_WIDTH      (AW),
    .INTERVAL_WIDTH (16)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_enable        (enable),
    .i_interval      (interval),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_op        (cmd_op),
    .i_cmd_mask      (cmd_mask),
    .i_cmd_data      (cmd_data),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_data      (rsp_data),
    .o_bf_valid      (bf_valid),
    .o_bf_write_mask (bf_mask),
    .o_bf_write_data (bf_data),
    .i_bf_read_data  (field),
    .i_acc_clear     (acc_clear),
    .o_acc_value     (acc_value),
    .o_acc_overflow  (acc_ovf)
  );

  // Counter bit field: masked write, then hardware increment.
  always @(posedge clk) begin
    nxt = field;
    if (load) nxt = load_val;
    else if (bf_valid)
      nxt = (field & ~bf_mask) | (bf_data & bf_mask);
    if (cnt_inc) begin
      nxt = nxt + 1'b1;
      inc_total <= inc_total + 1;
    end
    field <= nxt;
  end

  always @(negedge clk) begin
    if (mon_on && bf_valid) begin
      if (bf_mask == 4'hF && bf_data == 4'h0) begin
        polls = polls + 1;
        if (prev_poll) b2b = b2b + 1;
        prev_poll = 1'b1;
      end else begin
        hosts = hosts + 1;
        prev_poll = 1'b0;
      end
    end else begin
      prev_poll = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
  endtask

  task automatic load_field(input logic [W-1:0] v);
    @(negedge clk);
    load = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_cmd(input logic [2:0] op,
                        input logic [W-1:0] m,
                        input logic [W-1:0] d,
                        output logic [W-1:0] rsp,
                        output logic [W-1:0] bm,
                        output logic [W-1:0] bd,
                        output int waits);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_mask = m;
    cmd_data = d;
    waits = 0;
    while (!cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_bus_strobe", bf_valid, 1);
    bm = bf_mask;
    bd = bf_data;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_rsp_latency", n, 1);
    rsp = rsp_data;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  function automatic logic [7:0] exp_bus(
      input logic [2:0] op,
      input logic [W-1:0] m,
      input logic [W-1:0] d);
    case (op)
      3'd1:    return {m, d};
      3'd2:    return {m, 4'hF};
      3'd3:    return {m, 4'h0};
      3'd4:    return {4'hF, 4'h0};
      default: return 8'h00;
    endcase
  endfunction

  logic [W-1:0] r;
  logic [W-1:0] bm;
  logic [W-1:0] bd;
  int           wt;
  logic [W-1:0] ref_f;
  logic [W-1:0] m;
  logic [W-1:0] d;
  logic [2:0]   op;
  int           exp_acc;
  int           base;
  int           n;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bf_valid", bf_valid, 0);
    chk("rst_bf_mask", bf_mask, 0);
    chk("rst_acc", acc_value, 0);
    chk("rst_ovf", acc_ovf, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed READ with a held response.
    load_field(4'h9);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd0;
    chk("t1_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t1_bus_valid", bf_valid, 1);
    chk("t1_bus_md", {bf_mask, bf_data}, 0);
    @(negedge clk);
    chk("t1_bus_one_cycle", bf_valid, 0);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_data", rsp_data, 4'h9);
    repeat (3) begin
      @(negedge clk);
      chk("t1_hold_valid", rsp_valid, 1);
      chk("t1_hold_data", rsp_data, 4'h9);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t1_rsp_drop", rsp_valid, 0);

    // SET then CLEAR.
    load_field(4'h4);
    do_cmd(3'd2, 4'h3, 4'h0, r, bm, bd, wt);
    chk("set_bus", {bm, bd}, 8'h3F);
    chk("set_rsp", r, 4'h4);
    chk("set_field", field, 4'h7);
    do_cmd(3'd3, 4'h1, 4'hA, r, bm, bd, wt);
    chk("clr_bus", {bm, bd}, 8'h10);
    chk("clr_rsp", r, 4'h7);
    chk("clr_field", field, 4'h6);

    // Random host ops against a shadow field.
    @(negedge clk);
    acc_clear = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    exp_acc = 0;
    ref_f = 4'($urandom);
    load_field(ref_f);
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      m = 4'($urandom);
      d = 4'($urandom);
      do_cmd(op, m, d, r, bm, bd, wt);
      chk("rnd_rsp", r, ref_f);
      chk("rnd_bus", {bm, bd}, exp_bus(op, m, d));
      case (op)
        3'd1: ref_f = (ref_f & ~m) | (d & m);
        3'd2: ref_f = ref_f | m;
        3'd3: ref_f = ref_f & ~m;
        3'd4: begin
          exp_acc = exp_acc + ref_f;
          if (exp_acc > 255) exp_acc = 255;
          ref_f = 4'h0;
        end
        default: ;
      endcase
      chk("rnd_field", field, ref_f);
      chk("rnd_acc", acc_value, exp_acc);
    end

    // Lossless counting across read-clear polls.
    @(negedge clk);
    acc_clear = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    load_field(4'h0);
    base = inc_total;
    @(negedge clk);
    interval = 16'd3;
    enable = 1'b1;
    cnt_inc = 1'b1;
    repeat (200) @(negedge clk);
    cnt_inc = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    do_cmd(3'd4, 4'h0, 4'h0, r, bm, bd, wt);
    chk("cnt_total", inc_total - base, 200);
    chk("cnt_acc", acc_value, 200);
    chk("cnt_ovf", acc_ovf, 0);
    chk("cnt_field", field, 0);

    // Saturation and clear-with-read-clear.
    @(negedge clk);
    acc_clear = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    for (int i = 0; i < 17; i++) begin
      load_field(i == 16 ? 4'hC : 4'hF);
      do_cmd(3'd4, 4'h0, 4'h0, r, bm, bd, wt);
    end
    chk("sat_preload", acc_value, 8'hFC);
    load_field(4'h7);
    @(negedge clk);
    interval = 16'd0;
    enable = 1'b1;
    n = 0;
    while (!bf_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    chk("sat_poll_bus", {bf_valid, bf_mask, bf_data}, 9'h1F0);
    @(negedge clk);
    chk("sat_acc", acc_value, 8'hFF);
    chk("sat_ovf", acc_ovf, 1);
    load_field(4'h5);
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (!bf_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("clrrc_poll_seen", bf_valid, 1);
    acc_clear = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    acc_clear = 1'b0;
    chk("clrrc_acc", acc_value, 8'h05);
    chk("clrrc_ovf", acc_ovf, 0);

    // Arbitration under continuous polling.
    load_field(4'h0);
    @(negedge clk);
    interval = 16'd0;
    enable = 1'b1;
    mon_on = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      do_cmd(3'd0, 4'h0, 4'h0, r, bm, bd, wt);
      chk("alt_wait_le1", wt <= 1, 1);
    end
    @(negedge clk);
    mon_on = 1'b0;
    chk("alt_b2b_polls", b2b, 0);
    chk("alt_hosts", hosts, 4);
    chk("alt_polls_seen", polls >= 4, 1);

    // Reset while a response is pending.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd0;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rr_in_resp", rsp_valid, 1);
    chk("rr_acc_before", acc_value, 8'h05);
    rst_n = 1'b0;
    #1;
    chk("rr_rsp_valid", rsp_valid, 0);
    chk("rr_bf_valid", bf_valid, 0);
    chk("rr_acc", acc_value, 0);
    chk("rr_ovf", acc_ovf, 0);
    @(negedge clk);
    enable = 1'b0;
    rst_n = 1'b1;
    load_field(4'hA);
    do_cmd(3'd0, 4'h0, 4'h0, r, bm, bd, wt);
    chk("rr_read_rsp", r, 4'hA);
    chk("rr_read_bus", {bm, bd}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
